// File: rtl/poly_scheduler.sv
// poly_scheduler: two-port job scheduler evaluating A*X^2 + B*X + C with one
// shared W-bit ALU (add or multiply, truncated to W bits). Horner order:
// acc = a*x, acc += b, acc *= x, result = acc + c.
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   req_k, a_k..x_k         - port-k job request and operands (k = 0, 1)
//   gnt_k                   - combinational grant in IDLE; operands captured on this edge
//   done_k                  - one-cycle completion pulse for the owning port
//   result                  - last completed polynomial value
//   busy                    - high whenever the FSM is not in IDLE
//   job_count               - completed jobs, modulo 256
module poly_scheduler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_0,
    input  logic [W-1:0] a_0,
    input  logic [W-1:0] b_0,
    input  logic [W-1:0] c_0,
    input  logic [W-1:0] x_0,
    input  logic         req_1,
    input  logic [W-1:0] a_1,
    input  logic [W-1:0] b_1,
    input  logic [W-1:0] c_1,
    input  logic [W-1:0] x_1,
    output logic         gnt_0,
    output logic         gnt_1,
    output logic         done_0,
    output logic         done_1,
    output logic [W-1:0] result,
    output logic         busy,
    output logic [7:0]   job_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        ADD1 = 3'd2,
        MUL2 = 3'd3,
        ADD2 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;       // preferred port for the next grant
    logic         owner_q, owner_d;   // port that owns the job in flight
    logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] result_q, result_d;
    logic [7:0]   job_count_q, job_count_d;
    logic [1:0]   done_q, done_d;

    // Round-robin arbitration: the pointed-to port wins if requesting,
    // otherwise the other port.
    logic win_id;
    logic grant_en;

    always_comb begin
        win_id   = ptr_q ? req_1 : ~req_0;
        grant_en = (state_q == IDLE) && (req_0 || req_1);
        // Gated by reset_n so no grant is visible while reset is held.
        gnt_0    = reset_n && grant_en && !win_id;
        gnt_1    = reset_n && grant_en &&  win_id;
    end

    // Shared ALU: operand selection depends only on the current state.
    logic         alu_mul;
    logic [W-1:0] alu_x, alu_y, alu_out;

    always_comb begin
        alu_mul = 1'b0;
        alu_x   = acc_q;
        alu_y   = c_q;
        case (state_q)
            MUL1: begin alu_mul = 1'b1; alu_x = a_q;   alu_y = x_q; end
            ADD1: begin alu_mul = 1'b0; alu_x = acc_q; alu_y = b_q; end
            MUL2: begin alu_mul = 1'b1; alu_x = acc_q; alu_y = x_q; end
            default: begin alu_mul = 1'b0; alu_x = acc_q; alu_y = c_q; end
        endcase
        alu_out = alu_mul ? alu_x * alu_y : alu_x + alu_y;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        x_d         = x_q;
        acc_d       = acc_q;
        result_d    = result_q;
        job_count_d = job_count_q;
        done_d      = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    a_d     = win_id ? a_1 : a_0;
                    b_d     = win_id ? b_1 : b_0;
                    c_d     = win_id ? c_1 : c_0;
                    x_d     = win_id ? x_1 : x_0;
                    owner_d = win_id;
                    ptr_d   = ~win_id;
                    state_d = MUL1;
                end
            end
            MUL1: begin acc_d = alu_out; state_d = ADD1; end
            ADD1: begin acc_d = alu_out; state_d = MUL2; end
            MUL2: begin acc_d = alu_out; state_d = ADD2; end
            ADD2: begin
                result_d        = alu_out;
                job_count_d     = job_count_q + 8'd1;
                // done is registered so it lines up with the DONE state.
                done_d[owner_q] = 1'b1;
                state_d         = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;  // unreachable encodings recover
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            job_count_q <= '0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            job_count_q <= job_count_d;
            done_q      <= done_d;
        end
    end

    assign done_0    = done_q[0];
    assign done_1    = done_q[1];
    assign result    = result_q;
    assign busy      = (state_q != IDLE);
    assign job_count = job_count_q;

endmodule

// File: doc/poly_scheduler.md
POLY_SCHEDULER -- requirements
Module: poly_scheduler

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the operand, accumulator and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_0, input, 1 bit: port-0 job request; held high until granted.
REQ-005 The block SHALL have ports a_0, b_0, c_0 and x_0, input, W bits each: port-0 coefficients and argument, valid while req_0 is high.
REQ-006 The block SHALL have port req_1, input, 1 bit, with a_1, b_1, c_1, x_1 (W each): the same as port 0, for port 1.
REQ-007 The block SHALL have ports gnt_0 and gnt_1, output, 1 bit each: one-cycle grant, meaning operands are captured on this edge.
REQ-008 The block SHALL have ports done_0 and done_1, output, 1 bit each: one-cycle completion pulse for the owning port.
REQ-009 The block SHALL have port result, output, W bits: the last completed A*X^2+B*X+C, held until the next completion.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port job_count, output, 8 bits: number of completed jobs, modulo 256.

Function
REQ-012 The block SHALL time-share one internal ALU (add or multiply, W-bit, result truncated to W bits) between the two ports.
REQ-013 The block SHALL implement the states IDLE, MUL1, ADD1, MUL2, ADD2 and DONE, and no others.
REQ-014 In IDLE with neither request high, the block SHALL remain in IDLE with all grant and done outputs low.
REQ-015 In IDLE, the block SHALL drive exactly one gnt_k high combinationally when req_k is the arbitration winner.
REQ-016 On that edge the block SHALL capture a_k, b_k, c_k, x_k and the owner id k, then go to MUL1.
REQ-017 Arbitration SHALL be round-robin: a pointer names the preferred port, and that port wins if its req is high.
REQ-018 Otherwise the other port SHALL win if its req is high.
REQ-019 After each grant, the pointer SHALL move to the port that was not granted.
REQ-020 MUL1 SHALL update acc <= a*x, then go to ADD1.
REQ-021 ADD1 SHALL update acc <= acc+b, then go to MUL2.
REQ-022 MUL2 SHALL update acc <= acc*x, then go to ADD2.
REQ-023 ADD2 SHALL update result <= acc+c, increment job_count, then go to DONE.
REQ-024 In DONE, the block SHALL assert done_owner for one cycle with result already valid, then go to IDLE.
REQ-025 Latency SHALL be fixed: with the grant in cycle T, done occurs in cycle T+5.
REQ-026 The earliest next grant SHALL be in cycle T+6, giving a throughput of 1 job per 6 cycles.
REQ-027 Every intermediate value SHALL be truncated to W bits, with no saturation and no overflow flag.
REQ-028 job_count SHALL wrap from 255 to 0.
REQ-029 Requests SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-030 A requester SHALL keep req high until it is granted.
REQ-031 A deassertion of req_k after its grant SHALL NOT affect the job in flight.
REQ-032 Changes to operand inputs after the grant edge SHALL NOT affect the job in flight.
REQ-033 gnt_0 and gnt_1 SHALL never be high together, and done_0 and done_1 SHALL never be high together.
REQ-034 Any unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-035 While reset_n is low, independent of clk, the block SHALL drive state=IDLE, pointer=port 0 and acc=0.
REQ-036 While reset_n is low, the block SHALL drive result=0, job_count=0, and busy, gnt_0, gnt_1, done_0, done_1 all 0.
REQ-037 A reset during any state SHALL abort the job in flight with no done pulse and no result update.
REQ-038 The first rising edge with reset_n high SHALL evaluate IDLE normally.

Verification
REQ-039 The bench SHALL cover a single job on port 0: a=2, b=3, c=4, x=5, W=8.
  - Required response: gnt_0 in cycle T, done_0 in cycle T+5, result=69, job_count=1.
REQ-040 The bench SHALL cover a wrap-around job: a=3, b=7, c=200, x=10.
  - Required response: result=58, with intermediates 30, 37, 114 (=370 mod 256), 58.
REQ-041 The bench SHALL cover simultaneous requests from reset: req_0 and req_1 both held high.
  - Required response: port 0 is granted first and port 1 in cycle T+6.
  - Required response: done_0 and then done_1, 6 cycles apart, with no overlap of grants or dones.
REQ-042 The bench SHALL cover fairness: req_0 held high continuously, req_1 pulsed high until it is granted.
  - Required response: port 1 is granted at the next IDLE following a port-0 grant.
REQ-043 The bench SHALL cover reset in MUL2: reset_n pulled low asynchronously between clock edges.
  - Required response: outputs go to 0 immediately, and no done pulse follows.
  - Required response: a fresh job afterwards completes correctly.
REQ-044 The bench SHALL cover operand corruption: a_0 changed at T+1 after the grant.
  - Required response: the result matches the operands captured at T.
